// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command sequencer and its FIFO.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_DEC = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding {use_acc, op, a, b}; count-based full/empty, pointers wrap modulo DEPTH.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned ENTRY_W = 2 * WIDTH + 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives registered operands to a combinational ALU and returns results.
// Optional ALU_SEQ_FLAGS_EN adds captured res_zero / res_neg outputs.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             res_zero,
    output logic             res_neg,
`endif
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    localparam int unsigned ENTRY_W = 2 * WIDTH + 4;

    seq_state_t         state;
    logic               ready_q;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head;
    logic               head_use_acc;
    logic [2:0]         head_op;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;

    // ready_q keeps cmd_ready low through reset and until the first edge after release.
    assign cmd_ready = ready_q && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE) || !empty;

    assign head_use_acc = head[2*WIDTH+3];
    assign head_op      = head[2*WIDTH+2 -: 3];
    assign head_a       = head[2*WIDTH-1 -: WIDTH];
    assign head_b       = head[WIDTH-1:0];

    alu_cmd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({cmd_use_acc, cmd_op, cmd_a, cmd_b}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            acc       <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        alu_a   <= head_use_acc ? acc : head_a;
                        alu_b   <= head_b;
                        alu_sel <= head_op;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= alu_y;
                    res_cout  <= alu_cout;
                    acc       <= alu_y;
                    res_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                    res_zero  <= (alu_y == '0);
                    res_neg   <= alu_y[WIDTH-1];
`endif
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural 8-bit ALU.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_y;
    logic       alu_cout;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_cout;
    logic [7:0] acc;
    logic       busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic       res_zero;
    logic       res_neg;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_y       (alu_y),
        .alu_cout    (alu_cout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_cout    (res_cout),
`ifdef ALU_SEQ_FLAGS_EN
        .res_zero    (res_zero),
        .res_neg     (res_neg),
`endif
        .acc         (acc),
        .busy        (busy)
    );

    // Reference 8-bit ALU: 9-bit result, top bit is carry/borrow.
    logic [8:0] alu_r;
    always_comb begin
        alu_r = '0;
        case (alu_sel)
            OP_ADD:  alu_r = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_r = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  alu_r = {1'b0, alu_a & alu_b};
            OP_OR:   alu_r = {1'b0, alu_a | alu_b};
            OP_XOR:  alu_r = {1'b0, alu_a ^ alu_b};
            OP_NOT:  alu_r = {1'b0, ~alu_a};
            OP_INC:  alu_r = {1'b0, alu_a} + 9'd1;
            default: alu_r = {1'b0, alu_a} - 9'd1;
        endcase
    end
    assign alu_y    = alu_r[7:0];
    assign alu_cout = alu_r[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic ua);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
    endtask

    // Present one command and step through the accepting edge (bounded wait).
    task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic ua);
        int n;
        drive_cmd(op, a, b, ua);
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        check("res_valid_wait", res_valid, 1);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ua, input logic [7:0] ey,
                       input logic ec);
        push_cmd(op, a, b, ua);
        wait_res();
        check({tag, "_data"}, res_data, ey);
        check({tag, "_cout"}, res_cout, ec);
        check({tag, "_acc"}, acc, ey);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, res_valid, 0);
    endtask

    initial begin
        int         accepted;
        int         idx;
        logic [7:0] exp_q [5];
        logic       stale;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_use_acc = 1'b0;
        res_ready   = 1'b0;
        step();
        step();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_acc", acc, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_res_data", res_data, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_cmd_ready", cmd_ready, 1);

        // ADD 200+100 with exact latency: accept at N, load at N+1, result after N+2.
        drive_cmd(OP_ADD, 8'd200, 8'd100, 1'b0);
        step();
        cmd_valid = 1'b0;
        check("lat_n0_valid", res_valid, 0);
        check("lat_n0_busy", busy, 1);
        step();
        check("lat_n1_valid", res_valid, 0);
        check("lat_n1_alu_a", alu_a, 200);
        check("lat_n1_alu_b", alu_b, 100);
        check("lat_n1_alu_sel", alu_sel, OP_ADD);
        step();
        check("lat_n2_valid", res_valid, 1);
        check("add_data", res_data, 44);
        check("add_cout", res_cout, 1);
        check("add_acc", acc, 44);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("add_valid_drop", res_valid, 0);

        run("sub", OP_SUB, 8'd5, 8'd10, 1'b0, 8'd251, 1'b1);
        run("inc_acc", OP_INC, 8'h77, 8'd0, 1'b1, 8'd252, 1'b0);
        run("inc_wrap", OP_INC, 8'd255, 8'd0, 1'b0, 8'd0, 1'b1);
`ifdef ALU_SEQ_FLAGS_EN
        check("inc_wrap_zero", res_zero, 1);
        check("inc_wrap_neg", res_neg, 0);
`endif

        run("and", OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0);
        run("xor_acc", OP_XOR, 8'h00, 8'hFF, 1'b1, 8'hCF, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        check("xor_neg", res_neg, 1);
        check("xor_zero", res_zero, 0);
`endif
        run("not_acc", OP_NOT, 8'h00, 8'h00, 1'b1, 8'h30, 1'b0);
        run("dec_zero", OP_DEC, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1);

        // Backpressure: six back-to-back ADDs, only five fit (one in flight + four queued).
        for (int i = 0; i < 5; i++) begin
            exp_q[i] = 8'(i + 1) + 8'h10;
        end
        accepted = 0;
        idx      = 0;
        drive_cmd(OP_ADD, 8'd1, 8'h10, 1'b0);
        for (int c = 0; c < 12; c++) begin
            if (cmd_valid && cmd_ready) begin
                accepted++;
                idx++;
                step();
                drive_cmd(OP_ADD, 8'(idx + 1), 8'h10, 1'b0);
            end else begin
                step();
            end
        end
        check("bp_accepted", accepted, 5);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_busy", busy, 1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_res();
            check("bp_data", res_data, exp_q[i]);
            step();
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_data", res_data, exp_q[i]);
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
        end
        check("bp_drain_busy", busy, 0);

        // Reset while in RESP with three commands queued.
        push_cmd(OP_ADD, 8'd1, 8'd2, 1'b0);
        push_cmd(OP_ADD, 8'd3, 8'd4, 1'b0);
        push_cmd(OP_ADD, 8'd5, 8'd6, 1'b0);
        push_cmd(OP_ADD, 8'd7, 8'd8, 1'b0);
        wait_res();
        check("mid_data", res_data, 3);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_acc", acc, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        step();
        check("rel_cmd_ready", cmd_ready, 1);
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (res_valid || busy) stale = 1'b1;
            step();
        end
        check("no_stale_result", stale, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator side of the 8-bit ALU operand/opcode interface. Accepts ALU commands over a valid/ready stream, buffers them in a small FIFO, and drives registered operands and opcode to a combinational 8-bit ALU. It captures Y/Cout, maintains an accumulator for chained operations, and returns results over a valid/ready stream. Sits between a control/host block and the ALU datapath.

Parameters:
WIDTH, 8, operand/result width; must match the ALU.
DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO not full
cmd_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 INC A, 111 DEC A
cmd_a  input  WIDTH  operand A; ignored when cmd_use_acc=1
cmd_b  input  WIDTH  operand B
cmd_use_acc  input  1  take A from the accumulator
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_sel  output  3  registered opcode to ALU
alu_y  input  WIDTH  ALU result, combinational from alu_*
alu_cout  input  1  ALU carry/borrow out
res_valid  output  1  result present
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  captured result
res_cout  output  1  captured carry
acc  output  WIDTH  accumulator (last captured result)
busy  output  1  FSM not IDLE or FIFO non-empty

Behaviour:
- The interface uses one clock. Reset is synchronous and active-low: the clock port is clk and the reset port is rst_n.
- Reset (rst_n=0 at a rising edge) clears all outputs, the FIFO, the FSM, and acc to 0. cmd_ready is held 0 during reset and is 1 from the first edge after release. Reset mid-operation discards in-flight and buffered commands and drops res_valid with no handshake.
- Command handshake: a push occurs when cmd_valid && cmd_ready. cmd_ready = !full, computed from registered FIFO state. A push and a pop in the same cycle while full is not allowed because ready is low; a push and a pop in the same cycle otherwise is allowed and the count is unchanged.
- FIFO: pointers wrap modulo DEPTH. Full when count==DEPTH; empty when count==0.
- FSM, one command at a time:
  - IDLE: if FIFO non-empty, pop the head. Load alu_a = (use_acc ? acc : a), alu_b = b, alu_sel = op. Go to EXEC.
  - EXEC: the ALU settles combinationally. At the edge, capture res_data <= alu_y, res_cout <= alu_cout, acc <= alu_y, assert res_valid. Go to RESP.
  - RESP: hold res_valid and res_data stable until res_ready. On the handshake edge, deassert res_valid and go to IDLE.
- alu_a, alu_b and alu_sel hold their last values outside IDLE→EXEC loads.
- Latency: a command accepted at edge N into an empty FIFO with the FSM in IDLE is loaded at N+1. res_valid rises after edge N+2.
- Throughput: 1 result per 3 cycles when res_ready is held high.
- use_acc reads acc as committed at capture of the previous command. No forwarding hazard exists because execution is serial.
- Arithmetic: no width growth; WIDTH-bit wrap-around. Cout semantics are those of the ALU: carry for ADD/INC, 9th bit of the two's-complement difference for SUB/DEC, 0 for logic ops. The sequencer captures these values unmodified.

Optional Feature:
ALU_SEQ_FLAGS_EN
- Defined: adds output res_zero (1 bit, = res_data==0) and res_neg (1 bit, = res_data[WIDTH-1]). Both are captured in EXEC alongside res_data and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg: ALU_WIDTH=8; opcode constants OP_ADD…OP_DEC (3-bit); FSM state enum {IDLE, EXEC, RESP}.
- One sub-module alu_cmd_fifo (parameters WIDTH, DEPTH). It stores {use_acc, op, a, b} and exposes push/pop/full/empty/head.
- FSM and capture logic live in the top module.

Test Plan:
- Bench setup: alu_* ports are connected to the team's 8-bit ALU model.
- ADD a=200 b=100, res_ready=1 → res_data=44, res_cout=1, acc=44; res_valid rises exactly 2 edges after acceptance.
- SUB a=5 b=10 → res_data=251, res_cout=1. Then INC with use_acc=1 → res_data=252, res_cout=0.
- INC a=255 → res_data=0, res_cout=1. With ALU_SEQ_FLAGS_EN: res_zero=1, res_neg=0.
- Backpressure: res_ready=0, push 6 back-to-back commands → 5 accepted (1 in FSM + 4 in FIFO), cmd_ready=0. Release res_ready → 5 results returned in order, each held stable while stalled.
- Chain: AND a=0xF0 b=0x3C → 0x30, res_cout=0. Then XOR use_acc b=0xFF → 0xCF. Then NOT use_acc → 0x30. Then DEC a=0 → 0xFF, res_cout=1.
- Reset asserted while in RESP with 3 queued commands → next edge: res_valid=0, acc=0, busy=0, FIFO empty. No stale result appears after release.
